fft_out_reorder: RTL and testbench

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

---
 rtl/fft_out_reorder.sv | 126 ++++++++++++
 tb/tb_fft_out_reorder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong frame buffer that turns FFT output into natural order.
// Define FFT_OUT_REORDER_BITREV_EN for bit-reversed write addressing; without it frames pass in order.
module fft_out_reorder #(
    parameter int N = 2048
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [25:0] in_re,
    input  logic signed [25:0] in_im,
    output logic               out_valid,
    output logic signed [25:0] O_re,
    output logic signed [25:0] O_im,
    output logic               overflow
);
    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] wr_addr;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          out_valid_q;
    logic          wr_ok, accept, rd_en;
    logic [51:0]   mem [2*N];
    logic [51:0]   rd_data_q;

`ifdef FFT_OUT_REORDER_BITREV_EN
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < AW; i++) r[i] = k[AW-1-i];
        return r;
    endfunction
    assign wr_addr = bitrev(wr_cnt_q);
`else
    assign wr_addr = wr_cnt_q;
`endif

    // A bank released by DRAIN this edge may take a new sample on the same edge.
    assign wr_ok  = !full_q[wr_bank_q] || (state_q == DRAIN && rd_bank_q == wr_bank_q);
    assign accept = in_valid && wr_ok;
    assign rd_en  = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        rd_addr_d  = rd_addr_q;
        full_d     = full_q;
        overflow_d = overflow_q;

        if (state_q == DRAIN) full_d[rd_bank_q] = 1'b0;
        if (in_valid && !wr_ok) overflow_d = 1'b1;

        if (accept) begin
            if (wr_cnt_q == AW'(N - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_cnt_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        // Address N-1 is presented during DRAIN so the next frame's address 0
        // follows on the very next cycle, keeping out_valid gapless.
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = READ;
                    rd_addr_d = '0;
                end
            end
            READ: begin
                rd_addr_d = rd_addr_q + 1'b1;
                if (rd_addr_q == AW'(N - 2)) state_d = DRAIN;
            end
            DRAIN: begin
                rd_bank_d = ~rd_bank_q;
                rd_addr_d = '0;
                state_d   = full_q[~rd_bank_q] ? READ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            full_q      <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_q   <= rd_addr_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            out_valid_q <= rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[{wr_bank_q, wr_addr}] <= {in_re, in_im};
        if (rd_en) rd_data_q <= mem[{rd_bank_q, rd_addr_q}];
    end

    assign out_valid = out_valid_q;
    assign O_re      = out_valid_q ? $signed(rd_data_q[51:26]) : '0;
    assign O_im      = out_valid_q ? $signed(rd_data_q[25:0])  : '0;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: frame-level reference model plus per-cycle output compare.
// Honors FFT_OUT_REORDER_BITREV_EN the same way as the design.
module tb_fft_out_reorder;
    localparam int N  = 2048;
    localparam int AW = 11;
`ifdef FFT_OUT_REORDER_BITREV_EN
    localparam int PIN1 = 1024;
    localparam int PIN2 = 512;
`else
    localparam int PIN1 = 1;
    localparam int PIN2 = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic signed [25:0] in_re = '0, in_im = '0;
    logic out_valid, overflow;
    logic signed [25:0] O_re, O_im;

    fft_out_reorder #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .O_re(O_re), .O_im(O_im), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    int cyc = 0;

    // Reference model: frames collected per sample index, then scheduled as a block of expected outputs.
    logic [51:0] exp_q [int];
    logic [51:0] cur [N];
    int  free_q[$];
    int  wr_cnt, last_s, prev_s, last_l;
    bit  ovf_exp;
    int  run = 0, last_run = 0, rise_cyc = 0;

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < AW; i++) r |= ((k >> i) & 1) << (AW - 1 - i);
        return r;
    endfunction

    function automatic int src_idx(input int j);
`ifdef FFT_OUT_REORDER_BITREV_EN
        return brev(j);
`else
        return j;
`endif
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        free_q.delete();
        wr_cnt  = 0;
        last_s  = -100000;
        prev_s  = -100000;
        last_l  = 0;
        ovf_exp = 1'b0;
    endfunction

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    always @(posedge clk) begin : model
        int s;
        cyc = cyc + 1;
        if (!rst && in_valid) begin
            while (free_q.size() > 0 && free_q[0] <= cyc) void'(free_q.pop_front());
            if (free_q.size() == 2) begin
                ovf_exp = 1'b1;
            end else begin
                cur[wr_cnt] = {in_re, in_im};
                wr_cnt++;
                if (wr_cnt == N) begin
                    s = cyc + 2;
                    if (last_s + N > s) s = last_s + N;
                    for (int j = 0; j < N; j++) exp_q[s + j] = cur[src_idx(j)];
                    prev_s = last_s;
                    last_s = s;
                    last_l = cyc;
                    free_q.push_back(s + N - 1);
                    wr_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [51:0] e;
        bit ev;
        ev = exp_q.exists(cyc);
        e  = ev ? exp_q[cyc] : '0;
        check("out_valid", out_valid, ev);
        check("O_re", O_re, $signed(e[51:26]));
        check("O_im", O_im, $signed(e[25:0]));
        check("overflow", overflow, ovf_exp);
        if (out_valid) begin
            if (run == 0) rise_cyc = cyc;
            run++;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_re    = $signed(26'($urandom));
            in_im    = $signed(26'($urandom));
            @(posedge clk); #1;
        end
    endtask

    // mode 0: re=k,im=-k gapless; 1: random gapless; 2: re=k,im=-k toggling valid; 3: random with random gaps
    task automatic frame(input int mode, input int count);
        for (int k = 0; k < count; k++) begin
            if (mode == 3) while ($urandom_range(0, 3) == 0) idle(1);
            in_valid = 1'b1;
            if (mode == 0 || mode == 2) begin
                in_re = 26'(k);
                in_im = 26'(-k);
            end else begin
                in_re = $signed(26'($urandom));
                in_im = $signed(26'($urandom));
            end
            @(posedge clk); #1;
            if (mode == 2 && k != count - 1) idle(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (cyc < last_s + N + 1 && guard < 10 * N) begin
            idle(1);
            guard++;
        end
        check("drain_timeout", guard >= 10 * N, 0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        model_clear();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_O_re", O_re, 0);
        check("rst_O_im", O_im, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [51:0] pv;
        int guard;
        model_clear();
        @(posedge clk); #1;
        reset_pulse();

        // Single frame re=k, im=-k
        frame(0, N);
        check("model_latency", last_s - last_l, 2);
        pv = exp_q[last_s + 1];
        check("model_j1_re", $signed(pv[51:26]), PIN1);
        check("model_j1_im", $signed(pv[25:0]), -PIN1);
        pv = exp_q[last_s + 2];
        check("model_j2_re", $signed(pv[51:26]), PIN2);
        pv = exp_q[last_s + N - 1];
        check("model_jlast_im", $signed(pv[25:0]), -(N - 1));
        wait_drain();
        check("run_single", last_run, N);
        check("rise_latency", rise_cyc - last_l, 2);

        // Two frames back to back
        frame(1, N);
        frame(1, N);
        check("model_b2b", last_s - prev_s, N);
        wait_drain();
        check("run_two", last_run, 2 * N);
        check("overflow_two", overflow, 0);

        // Toggling in_valid
        frame(2, N);
        wait_drain();
        check("run_toggle", last_run, N);

        // Frames separated by 1..3 idle cycles around the DRAIN boundary
        frame(1, N);
        for (int g = 1; g <= 3; g++) begin
            idle(g);
            frame(1, N);
        end
        wait_drain();

        // Random gaps
        frame(3, N);
        wait_drain();
        check("run_gappy", last_run, N);

        // Three frames at full rate
        frame(1, N);
        frame(1, N);
        frame(1, N);
        wait_drain();
        check("run_three", last_run, 3 * N);
        check("overflow_three", overflow, ovf_exp);

        // Reset during output cycle 1000, then a fresh frame
        frame(0, N);
        guard = 0;
        while (cyc < last_s + 1000 && guard < 10 * N) begin
            idle(1);
            guard++;
        end
        check("reach_out1000", out_valid, 1);
        reset_pulse();
        frame(1, N);
        wait_drain();
        check("run_after_rst", last_run, N);

        // Partial frame discarded by reset
        frame(1, 700);
        reset_pulse();
        frame(0, N);
        wait_drain();
        check("run_after_partial", last_run, N);
        check("rise_after_partial", rise_cyc - last_l, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
